// File: rtl/nibble_serial_add_pkg.sv
// Shared definitions for the multi-nibble stages built around the 4-bit ripple adder.
package nibble_serial_add_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_add_nibble_sel.sv
// Combinational mux picking nibble idx out of a multi-nibble vector.
module nibble_sel
  import nibble_serial_add_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = $clog2(NIBBLES)
) (
  input  logic [NIBBLE_W*NIBBLES-1:0] vec,
  input  logic [IDX_W-1:0]            idx,
  output logic [NIBBLE_W-1:0]         nib
);
  // Pad to a power of two so every idx value selects a defined slot.
  localparam int SLOTS = 1 << IDX_W;

  logic [NIBBLE_W-1:0] slot [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NIBBLES) begin : g_used
        assign slot[gi] = vec[gi*NIBBLE_W +: NIBBLE_W];
      end else begin : g_pad
        assign slot[gi] = '0;
      end
    end
  endgenerate

  assign nib = slot[idx];
endmodule

// File: rtl/nibble_serial_add.sv
// Runs a wide addition through one external 4-bit adder, one nibble per cycle, LSB first.
module nibble_serial_add
  import nibble_serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                        in_cin,
  output logic [NIBBLE_W-1:0]         add_a,
  output logic [NIBBLE_W-1:0]         add_b,
  output logic                        add_c,
  input  logic [NIBBLE_W-1:0]         add_sum,
  input  logic                        add_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_ovf
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg, sum_reg, sum_upd;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [NIBBLE_W-1:0] a_nib, b_nib;
  logic             last_nib;

  nibble_sel #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_sel_a (
    .vec (a_reg),
    .idx (idx_reg),
    .nib (a_nib)
  );

  nibble_sel #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_sel_b (
    .vec (b_reg),
    .idx (idx_reg),
    .nib (b_nib)
  );

  // Only the nibble addressed by idx takes the adder result; the rest hold.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_sum
      assign sum_upd[gi*NIBBLE_W +: NIBBLE_W] =
        (idx_reg == IDX_W'(gi)) ? add_sum : sum_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  assign last_nib = (idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_upd;
          carry_reg <= add_cout;
          // idx parks on the last nibble instead of wrapping.
          idx_reg   <= last_nib ? idx_reg : idx_reg + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_sum    = '0;
    out_cout   = 1'b0;
    out_ovf    = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a = a_nib;
        add_b = b_nib;
        add_c = carry_reg;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = sum_reg;
        out_cout  = carry_reg;
        out_ovf   = (a_reg[W-1] == b_reg[W-1]) && (sum_reg[W-1] != a_reg[W-1]);
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_nibble_serial_add.sv
// Directed bench for nibble_serial_add with a 4-bit ripple adder model and a result scoreboard.
module tb_nibble_serial_add;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [N-1:0] carries;
  } op_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_c, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // The existing 4-bit ripple adder, closed around the add_* ports.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_c);

  nibble_serial_add #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes one expectation per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum=%0h with no pending operation", out_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_cout", 32'(out_cout), 32'(e.cout));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        $display("result sum=%h cout=%0d ovf=%0d", out_sum, out_cout, out_ovf);
      end
    end
  end

  // Called just after a rising edge with the DUT idle.
  task automatic run_op(input op_t o, input int hold);
    logic [W-1:0] s_sum;
    logic         s_cout, s_ovf;
    sb.push_back('{o.sum, o.cout, o.ovf});
    out_ready = (hold == 0);
    in_a = o.a; in_b = o.b; in_cin = o.cin; in_valid = 1'b1;
    #1 chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after the accept edge: the block must ignore them.
    in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = ~o.cin;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("run_add_a", 32'(add_a), 32'(o.a[4*k +: 4]));
      chk("run_add_b", 32'(add_b), 32'(o.b[4*k +: 4]));
      chk("run_add_c", 32'(add_c), 32'(o.carries[k]));
      chk("run_out_valid", 32'(out_valid), 32'd0);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_add_a", 32'(add_a), 32'd0);
    if (hold > 0) begin
      s_sum = out_sum; s_cout = out_cout; s_ovf = out_ovf;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_sum", 32'(out_sum), 32'(s_sum));
        chk("bp_out_cout", 32'(out_cout), 32'(s_cout));
        chk("bp_out_ovf", 32'(out_ovf), 32'(s_ovf));
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    $display("op a=%h b=%h cin=%0d expect sum=%h cout=%0d ovf=%0d", o.a, o.b, o.cin, o.sum, o.cout, o.ovf);
  endtask

  op_t ops[5];

  initial begin
    ops[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 4'b0000};
    ops[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
    ops[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
    ops[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
    ops[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_add", 32'({add_a, add_b, add_c}), 32'd0);
    chk("idle_out_sum", 32'(out_sum), 32'd0);
    chk("idle_out_flags", 32'({out_cout, out_ovf}), 32'd0);
    $display("reset checked");

    run_op(ops[0], 0);
    run_op(ops[1], 0);
    run_op(ops[2], 10);
    run_op(ops[3], 0);

    // Abort an operation partway through RUN; nothing may come out of it.
    in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_add", 32'({add_a, add_b, add_c}), 32'd0);
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    $display("mid-run reset checked");
    run_op(ops[4], 0);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end
endmodule
